ad_frame_sched: RTL and testbench

Frame scheduler in the GMII transmit clock domain, between the read side of the AD sample FIFO and the UDP transmitter. It watches the FIFO fill level and decides when a frame is sent and how many payload bytes it carries: full frames of FRAME_BYTES, or a shorter flush frame when data has sat idle too long. It issues the transmitter's start pulse and byte count, gates the transmitter's read requests into FIFO read enables, and enforces a minimum gap between frames.

---
 rtl/ad_frame_sched.sv | 93 +++++++++
 tb/tb_ad_frame_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ad_frame_sched.sv
// Frame scheduler between the AD sample FIFO read side and the UDP transmitter.
// Decides full/flush frames, gates transmitter requests into FIFO reads, enforces a gap.
module ad_frame_sched #(
  parameter int unsigned FRAME_BYTES   = 1024,
  parameter int unsigned MIN_BYTES     = 18,
  parameter int unsigned FLUSH_TIMEOUT = 125000,
  parameter int unsigned IFG_CYCLES    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] fifo_rd_cnt,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        busy,
  output logic [31:0] frame_cnt,
  output logic        underrun
);

  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam int GW = $clog2(IFG_CYCLES + 1);
  localparam logic [TW-1:0] TMAX  = TW'(FLUSH_TIMEOUT);
  localparam logic [GW-1:0] GLAST = GW'(IFG_CYCLES - 1);
  localparam logic [15:0]   FB    = 16'(FRAME_BYTES);
  localparam logic [15:0]   MB    = 16'(MIN_BYTES);

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  state_t          state;
  state_t          state_nx;
  logic [TW-1:0]   tmr;
  logic [GW-1:0]   gcnt;
  logic [15:0]     remain;
  logic            full_hit;
  logic            flush_hit;
  logic            take;

  assign full_hit  = fifo_rd_cnt >= FB;
  assign flush_hit = (tmr == TMAX) && (fifo_rd_cnt >= MB);
  assign take      = (state == SEND) && tx_req && (remain != 16'd0);

  // rst_n gating keeps reads off for the whole reset cycle, not just after the edge
  assign fifo_rd_en  = rst_n & take & ~fifo_empty;
  assign tx_start_en = (state == START);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (full_hit || flush_hit) state_nx = START;
      START: state_nx = SEND;
      SEND:  if (tx_done) state_nx = GAP;
      GAP:   if (gcnt == GLAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr         <= '0;
      gcnt        <= '0;
      remain      <= '0;
      tx_byte_num <= '0;
      frame_cnt   <= '0;
      underrun    <= 1'b0;
    end else begin
      underrun <= take & fifo_empty;

      if (state != IDLE || fifo_rd_cnt == 16'd0) tmr <= '0;
      else if (tmr != TMAX)                      tmr <= tmr + 1'b1;

      if (state == IDLE && state_nx == START)
        tx_byte_num <= full_hit ? FB : fifo_rd_cnt;

      // remain counts requests, not reads, so underruns keep the frame length
      if (state == START) remain <= tx_byte_num;
      else if (take)      remain <= remain - 16'd1;

      if (state == SEND && tx_done) frame_cnt <= frame_cnt + 32'd1;

      gcnt <= (state == GAP) ? gcnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_ad_frame_sched.sv
// Bench for ad_frame_sched: per-cycle vector table plus multi-cycle frame sequences.
module tb_ad_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] fifo_rd_cnt;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req;
  logic        tx_done;
  logic        busy;
  logic [31:0] frame_cnt;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  ad_frame_sched #(
    .FRAME_BYTES(1024),
    .MIN_BYTES(18),
    .FLUSH_TIMEOUT(100),
    .IFG_CYCLES(12)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fifo_rd_cnt(fifo_rd_cnt),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .tx_start_en(tx_start_en),
    .tx_byte_num(tx_byte_num),
    .tx_req(tx_req),
    .tx_done(tx_done),
    .busy(busy),
    .frame_cnt(frame_cnt),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] cnt;
    logic        req;
    logic        emp;
    logic        done;
    logic        e_rd;
    logic        e_st;
    logic [15:0] e_num;
    logic        e_busy;
    logic        e_und;
    logic [31:0] e_fc;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // inputs change at the falling edge; outputs are read 1 ns later
  task automatic drive(input logic r, input logic [15:0] c,
                       input logic q, input logic e, input logic d);
    @(negedge clk);
    rst_n = r; fifo_rd_cnt = c; tx_req = q; fifo_empty = e; tx_done = d;
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
  endtask

  // k = index of the cycle showing tx_start_en (0 = first driven cycle), -1 on timeout
  task automatic wait_start(input logic [15:0] c, input int lim, output int k);
    k = -1;
    for (int i = 0; i < lim; i++) begin
      drive(1, c, 0, 0, 0);
      if (tx_start_en) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic run_frame(input int nreq, input int e_lo, input int e_hi,
                           input logic [15:0] c, output int rdc, output int undc);
    rdc = 0;
    undc = 0;
    for (int i = 0; i < nreq; i++) begin
      drive(1, c, 1, (i >= e_lo && i <= e_hi), 0);
      rdc += int'(fifo_rd_en);
      undc += int'(underrun);
    end
    drive(1, c, 0, 0, 1);
    undc += int'(underrun);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, rdc, undc;
    rst_n = 0; fifo_rd_cnt = 0; fifo_empty = 0; tx_req = 0; tx_done = 0;

    //          rst cnt   req emp dn  rd st num   bsy und fc
    tbl[0] = '{0, 0,    1,  0,  0,  0, 0, 0,    0,  0,  0};
    tbl[1] = '{1, 1024, 1,  0,  0,  0, 0, 0,    0,  0,  0};
    tbl[2] = '{1, 1024, 1,  0,  1,  0, 1, 1024, 1,  0,  0};
    tbl[3] = '{1, 1024, 1,  0,  0,  1, 0, 1024, 1,  0,  0};
    tbl[4] = '{1, 1024, 1,  1,  0,  0, 0, 1024, 1,  0,  0};
    tbl[5] = '{1, 1024, 0,  0,  1,  0, 0, 1024, 1,  1,  0};
    tbl[6] = '{1, 1024, 1,  0,  1,  0, 0, 1024, 1,  0,  1};
    tbl[7] = '{1, 1024, 0,  0,  0,  0, 0, 1024, 1,  0,  1};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].rst, tbl[i].cnt, tbl[i].req, tbl[i].emp, tbl[i].done);
      chk($sformatf("v%0d rd_en", i), 32'(fifo_rd_en), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d start", i), 32'(tx_start_en), 32'(tbl[i].e_st));
      chk($sformatf("v%0d byte_num", i), 32'(tx_byte_num), 32'(tbl[i].e_num));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d underrun", i), 32'(underrun), 32'(tbl[i].e_und));
      chk($sformatf("v%0d frame_cnt", i), frame_cnt, tbl[i].e_fc);
    end

    // full frame, then back-to-back second frame with overruns and empties
    do_reset();
    wait_start(1024, 10, k);
    chk("full start", 32'(k), 32'd1);
    chk("full byte_num", 32'(tx_byte_num), 32'd1024);
    run_frame(1024, -1, -1, 1024, rdc, undc);
    chk("full reads", 32'(rdc), 32'd1024);
    chk("full underruns", 32'(undc), 32'd0);
    // k=0 is the cycle after tx_done, so 14 cycles after done means k=13
    wait_start(1024, 40, k);
    chk("b2b interval", 32'(k), 32'd13);
    chk("b2b frame_cnt", frame_cnt, 32'd1);
    chk("b2b byte_num", 32'(tx_byte_num), 32'd1024);
    run_frame(1030, 100, 102, 1024, rdc, undc);
    chk("over reads", 32'(rdc), 32'd1021);
    chk("over underruns", 32'(undc), 32'd3);
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    chk("stray done frame_cnt", frame_cnt, 32'd2);
    chk("stray done busy", 32'(busy), 32'd1);

    // timeout flush of a static 500-byte count
    do_reset();
    wait_start(500, 200, k);
    chk("flush delay", 32'(k), 32'd101);
    chk("flush byte_num", 32'(tx_byte_num), 32'd500);

    // below MIN_BYTES past timeout, then count reaches MIN_BYTES
    do_reset();
    wait_start(10, 150, k);
    chk("min hold", 32'(k), 32'hFFFF_FFFF);
    wait_start(18, 10, k);
    chk("min start", 32'(k), 32'd1);
    chk("min byte_num", 32'(tx_byte_num), 32'd18);

    // reset in the middle of SEND
    do_reset();
    wait_start(2048, 10, k);
    chk("rst start", 32'(k), 32'd1);
    for (int i = 0; i < 50; i++) drive(1, 2048, 1, 0, 0);
    chk("rst pre rd_en", 32'(fifo_rd_en), 32'd1);
    drive(0, 2048, 1, 0, 0);
    chk("rst rd_en low", 32'(fifo_rd_en), 32'd0);
    drive(1, 2048, 1, 0, 0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst byte_num", 32'(tx_byte_num), 32'd0);
    chk("rst start_en", 32'(tx_start_en), 32'd0);
    chk("rst rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst frame_cnt", frame_cnt, 32'd0);
    wait_start(2048, 10, k);
    chk("rst restart", 32'(k), 32'd0);
    chk("rst restart byte_num", 32'(tx_byte_num), 32'd1024);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
